// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage registers: default widths, the NOP
// bubble value and the stage occupancy encoding.
package pipe_pkg;

  localparam int unsigned INST_WIDTH     = 32;
  localparam int unsigned SYS_ADDR_SPACE = 32;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } stage_state_e;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage register with optional two-entry skid buffer,
// synchronous flush that injects a NOP bubble, and stall/flush event counters.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W    = INST_WIDTH,
  parameter int unsigned       ADDR_W    = SYS_ADDR_SPACE,
  parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(NOP_INSTR_DEF),
  parameter bit                SKID      = 1'b1,
  parameter int unsigned       CNT_W     = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] instr_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              flush_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] instr_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  stage_state_e      state_q, state_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] skid_instr;
  logic [ADDR_W-1:0] skid_pc;
  logic              skid_load;
  logic              in_ready;
  logic              out_valid;
  logic              in_xfer;
  logic              out_xfer;

  assign out_valid = (state_q != ST_EMPTY);
  assign in_xfer   = in_valid_i & in_ready;
  assign out_xfer  = out_valid & out_ready_i;

  // Stage 0: occupancy FSM and main register load selection
  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    pc_d      = pc_q;
    skid_load = 1'b0;
    unique case (state_q)
      ST_EMPTY: begin
        if (in_xfer) begin
          state_d = ST_FULL;
          instr_d = instr_i;
          pc_d    = pc_i;
        end
      end
      ST_FULL: begin
        if (in_xfer && out_xfer) begin
          instr_d = instr_i;
          pc_d    = pc_i;
        end else if (in_xfer && SKID) begin
          state_d   = ST_SKID;
          skid_load = 1'b1;
        end else if (out_xfer) begin
          state_d = ST_EMPTY;
        end
      end
      ST_SKID: begin
        if (out_xfer) begin
          state_d = ST_FULL;
          instr_d = skid_instr;
          pc_d    = skid_pc;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush beats every transfer; PC keeps its last value for debug visibility.
    if (flush_i) begin
      state_d   = ST_EMPTY;
      pc_d      = pc_q;
      skid_load = 1'b0;
    end
    if (state_d == ST_EMPTY) begin
      instr_d = NOP_INSTR;
    end
  end

  // Stage 1: main output register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_EMPTY;
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  generate
    if (SKID) begin : g_skid
      logic              in_ready_q, in_ready_d;
      logic [DATA_W-1:0] skid_instr_q, skid_instr_d;
      logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;

      // Registered ready: only the skid-occupied state refuses input.
      always_comb begin
        in_ready_d   = (state_d != ST_SKID);
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        if (skid_load) begin
          skid_instr_d = instr_i;
          skid_pc_d    = pc_i;
        end
      end

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          in_ready_q <= 1'b1;
        end else begin
          in_ready_q <= in_ready_d;
        end
      end

      always_ff @(posedge clk_i) begin
        skid_instr_q <= skid_instr_d;
        skid_pc_q    <= skid_pc_d;
      end

      assign in_ready   = in_ready_q;
      assign skid_instr = skid_instr_q;
      assign skid_pc    = skid_pc_q;
    end else begin : g_noskid
      assign in_ready   = !out_valid | out_ready_i;
      assign skid_instr = '0;
      assign skid_pc    = '0;
    end
  endgenerate

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (out_valid & ~out_ready_i),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (flush_i),
    .cnt_o (flush_cnt_o)
  );

  assign in_ready_o  = in_ready;
  assign out_valid_o = out_valid;
  assign instr_o     = instr_q;
  assign pc_o        = pc_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: a SKID=1 instance with 4-bit counters and
// a SKID=0 instance with 16-bit counters, both driven by the same stimulus.
module tb_pipe_stage_skid;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] instr_in = '0;
  logic [31:0] pc_in = '0;

  logic        r1, ov1, r0, ov0;
  logic [31:0] io1, po1, io0, po0;
  logic [3:0]  sc1, fc1;
  logic [15:0] sc0, fc0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.SKID(1'b1), .CNT_W(4)) u_dut_skid (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(r1),
    .instr_i(instr_in), .pc_i(pc_in), .flush_i(flush), .out_valid_o(ov1),
    .out_ready_i(out_ready), .instr_o(io1), .pc_o(po1),
    .stall_cnt_o(sc1), .flush_cnt_o(fc1)
  );

  pipe_stage_skid #(.SKID(1'b0), .CNT_W(16)) u_dut_noskid (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(r0),
    .instr_i(instr_in), .pc_i(pc_in), .flush_i(flush), .out_valid_o(ov0),
    .out_ready_i(out_ready), .instr_o(io0), .pc_o(po0),
    .stall_cnt_o(sc0), .flush_cnt_o(fc0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc);
    in_valid = v;
    pc_in    = pc;
    instr_in = 32'hA500_0000 ^ pc;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0; drive(1'b0, 32'h0);
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (ov1 !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %0h want 0", ov1); end
    n_cmp++; if (io1 !== NOP) begin n_err++; $display("FAIL reset_instr got %0h want %0h", io1, NOP); end
    n_cmp++; if (po1 !== 32'h0) begin n_err++; $display("FAIL reset_pc got %0h want 0", po1); end
    n_cmp++; if (sc1 !== 4'd0) begin n_err++; $display("FAIL reset_stall_cnt got %0d want 0", sc1); end
    n_cmp++; if (fc1 !== 4'd0) begin n_err++; $display("FAIL reset_flush_cnt got %0d want 0", fc1); end
    n_cmp++; if (r1 !== 1'b1) begin n_err++; $display("FAIL reset_in_ready_skid got %0h want 1", r1); end
    n_cmp++; if (r0 !== 1'b1) begin n_err++; $display("FAIL reset_in_ready_noskid got %0h want 1", r0); end
    n_cmp++; if (io0 !== NOP) begin n_err++; $display("FAIL reset_instr_noskid got %0h want %0h", io0, NOP); end
  endtask

  task automatic test_stream();
    logic [31:0] pc;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pc = 32'(4 * i);
      drive(1'b1, pc);
      tick();
      n_cmp++; if (ov1 !== 1'b1) begin n_err++; $display("FAIL stream_valid[%0d] got %0h want 1", i, ov1); end
      n_cmp++; if (po1 !== pc) begin n_err++; $display("FAIL stream_pc[%0d] got %0h want %0h", i, po1, pc); end
      n_cmp++; if (io1 !== (32'hA500_0000 ^ pc)) begin n_err++; $display("FAIL stream_instr[%0d] got %0h want %0h", i, io1, 32'hA500_0000 ^ pc); end
      n_cmp++; if (po0 !== pc) begin n_err++; $display("FAIL stream_pc_noskid[%0d] got %0h want %0h", i, po0, pc); end
    end
    drive(1'b0, 32'h0);
    tick();
    n_cmp++; if (ov1 !== 1'b0) begin n_err++; $display("FAIL stream_drain_valid got %0h want 0", ov1); end
    n_cmp++; if (io1 !== NOP) begin n_err++; $display("FAIL stream_drain_instr got %0h want %0h", io1, NOP); end
    n_cmp++; if (po1 !== 32'h8) begin n_err++; $display("FAIL stream_drain_pc got %0h want 8", po1); end
    n_cmp++; if (sc1 !== 4'd0) begin n_err++; $display("FAIL stream_stall_cnt got %0d want 0", sc1); end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b1; drive(1'b1, 32'h100);
    tick();
    out_ready = 1'b0; drive(1'b1, 32'h104);
    tick();
    n_cmp++; if (po1 !== 32'h100) begin n_err++; $display("FAIL bp_held_pc got %0h want 100", po1); end
    n_cmp++; if (r1 !== 1'b0) begin n_err++; $display("FAIL bp_in_ready got %0h want 0", r1); end
    n_cmp++; if (sc1 !== 4'd1) begin n_err++; $display("FAIL bp_stall_cnt got %0d want 1", sc1); end
    drive(1'b1, 32'h108);
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++; if (po1 !== 32'h100 || ov1 !== 1'b1) begin n_err++; $display("FAIL bp_hold[%0d] got pc %0h valid %0h want pc 100 valid 1", k, po1, ov1); end
      n_cmp++; if (r1 !== 1'b0) begin n_err++; $display("FAIL bp_hold_ready[%0d] got %0h want 0", k, r1); end
      n_cmp++; if (sc1 !== 4'(k + 2)) begin n_err++; $display("FAIL bp_hold_stall[%0d] got %0d want %0d", k, sc1, k + 2); end
    end
    out_ready = 1'b1;
    tick();
    n_cmp++; if (po1 !== 32'h104) begin n_err++; $display("FAIL bp_skid_out_pc got %0h want 104", po1); end
    n_cmp++; if (r1 !== 1'b1) begin n_err++; $display("FAIL bp_ready_back got %0h want 1", r1); end
    tick();
    n_cmp++; if (po1 !== 32'h108 || ov1 !== 1'b1) begin n_err++; $display("FAIL bp_third_pc got %0h valid %0h want 108 valid 1", po1, ov1); end
    drive(1'b0, 32'h0);
    tick();
    n_cmp++; if (ov1 !== 1'b0) begin n_err++; $display("FAIL bp_drain_valid got %0h want 0", ov1); end
    n_cmp++; if (sc1 !== 4'd4) begin n_err++; $display("FAIL bp_final_stall got %0d want 4", sc1); end
  endtask

  task automatic test_noskid_backpressure();
    do_reset();
    out_ready = 1'b1; drive(1'b1, 32'h200);
    tick();
    out_ready = 1'b0; drive(1'b1, 32'h204);
    #1;
    n_cmp++; if (r0 !== 1'b0) begin n_err++; $display("FAIL ns_comb_ready got %0h want 0", r0); end
    tick();
    n_cmp++; if (po0 !== 32'h200 || ov0 !== 1'b1) begin n_err++; $display("FAIL ns_held got pc %0h valid %0h want 200 valid 1", po0, ov0); end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (r0 !== 1'b1) begin n_err++; $display("FAIL ns_comb_ready_release got %0h want 1", r0); end
    tick();
    n_cmp++; if (po0 !== 32'h204 || ov0 !== 1'b1) begin n_err++; $display("FAIL ns_next got pc %0h valid %0h want 204 valid 1", po0, ov0); end
    drive(1'b0, 32'h0);
    tick();
    n_cmp++; if (ov0 !== 1'b0 || po0 !== 32'h204) begin n_err++; $display("FAIL ns_drain got pc %0h valid %0h want 204 valid 0", po0, ov0); end
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 1'b1; drive(1'b1, 32'h300);
    tick();
    out_ready = 1'b0; drive(1'b1, 32'h304);
    tick();
    n_cmp++; if (r1 !== 1'b0) begin n_err++; $display("FAIL fl_skid_state_ready got %0h want 0", r1); end
    flush = 1'b1; drive(1'b1, 32'h308);
    tick();
    n_cmp++; if (ov1 !== 1'b0) begin n_err++; $display("FAIL fl_valid got %0h want 0", ov1); end
    n_cmp++; if (io1 !== NOP) begin n_err++; $display("FAIL fl_instr got %0h want %0h", io1, NOP); end
    n_cmp++; if (po1 !== 32'h300) begin n_err++; $display("FAIL fl_pc_kept got %0h want 300", po1); end
    n_cmp++; if (fc1 !== 4'd1) begin n_err++; $display("FAIL fl_cnt got %0d want 1", fc1); end
    n_cmp++; if (r1 !== 1'b1) begin n_err++; $display("FAIL fl_ready got %0h want 1", r1); end
    flush = 1'b0; drive(1'b0, 32'h0); out_ready = 1'b1;
    tick();
    n_cmp++; if (ov1 !== 1'b0) begin n_err++; $display("FAIL fl_no_ghost got %0h want 0", ov1); end
    drive(1'b1, 32'h310);
    tick();
    flush = 1'b1; drive(1'b1, 32'h314);
    tick();
    n_cmp++; if (ov1 !== 1'b0 || po1 !== 32'h310) begin n_err++; $display("FAIL fl_full_drop got pc %0h valid %0h want 310 valid 0", po1, ov1); end
    n_cmp++; if (fc1 !== 4'd2) begin n_err++; $display("FAIL fl_cnt2 got %0d want 2", fc1); end
    flush = 1'b0; drive(1'b0, 32'h0);
    tick();
    n_cmp++; if (ov1 !== 1'b0) begin n_err++; $display("FAIL fl_full_no_ghost got %0h want 0", ov1); end
  endtask

  task automatic test_saturation();
    do_reset();
    drive(1'b1, 32'h400);
    tick();
    drive(1'b0, 32'h0);
    for (int k = 0; k < 20; k++) tick();
    n_cmp++; if (sc1 !== 4'd15) begin n_err++; $display("FAIL sat_stall_4b got %0d want 15", sc1); end
    n_cmp++; if (sc0 !== 16'd20) begin n_err++; $display("FAIL sat_stall_16b got %0d want 20", sc0); end
    n_cmp++; if (ov1 !== 1'b1 || po1 !== 32'h400) begin n_err++; $display("FAIL sat_held got pc %0h valid %0h want 400 valid 1", po1, ov1); end
  endtask

  task automatic test_mid_reset();
    flush = 1'b1;
    tick();
    flush = 1'b0; drive(1'b1, 32'h500);
    tick();
    drive(1'b0, 32'h0);
    n_cmp++; if (ov1 !== 1'b1 || po1 !== 32'h500 || fc1 !== 4'd1) begin n_err++; $display("FAIL mr_pre got pc %0h valid %0h fcnt %0d want 500 1 1", po1, ov1, fc1); end
    rst = 1'b1;
    tick();
    n_cmp++; if (ov1 !== 1'b0) begin n_err++; $display("FAIL mr_valid got %0h want 0", ov1); end
    n_cmp++; if (po1 !== 32'h0 || io1 !== NOP) begin n_err++; $display("FAIL mr_data got pc %0h instr %0h want 0 %0h", po1, io1, NOP); end
    n_cmp++; if (sc1 !== 4'd0 || fc1 !== 4'd0) begin n_err++; $display("FAIL mr_counters got %0d %0d want 0 0", sc1, fc1); end
    n_cmp++; if (r1 !== 1'b1) begin n_err++; $display("FAIL mr_ready got %0h want 1", r1); end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_noskid_backpressure();
    test_flush();
    test_saturation();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
